axi_burst_splitter_b_merge: RTL
===============================

# axi_burst_splitter_b_merge

Write-response merge stage of the AXI burst splitter. Downstream returns one B beat per split single-beat write. This block consumes those beats through the shared per-ID burst counters and returns exactly one B response upstream per original burst, carrying the worst-case response of the burst. It is the direct consumer of the counter interface exposed by the AW-side splitter channel and sits on the B path between the memory-side port and the upstream slave port.

## Interface

Parameters:
- `IdWidth`, default 0 — AXI ID width; the counter ID is the same width.
- `UserWidth`, default 0 — B user width.

B channel payload is packed `{id[IdWidth], resp[2], user[UserWidth]}`, with the ID at the MSBs. `BW = IdWidth+2+UserWidth`.

Ports:
- `clk_i` — in, 1 — clock.
- `rst_ni` — in, 1 — asynchronous, active-low reset.
- `b_i` — in, BW — split-beat B response from downstream.
- `b_valid_i` — in, 1 — downstream beat valid.
- `b_ready_o` — out, 1 — downstream beat accepted.
- `b_o` — out, BW — merged B response to upstream.
- `b_valid_o` — out, 1 — merged response valid.
- `b_ready_i` — in, 1 — upstream ready.
- `cnt_id_o` — out, IdWidth — counter lookup ID (= `b_i.id`).
- `cnt_len_i` — in, 8 — remaining beats for `cnt_id_o`; 0 means the current beat is last.
- `cnt_set_err_o` — out, 1 — set sticky error for `cnt_id_o`.
- `cnt_err_i` — in, 1 — sticky error of `cnt_id_o`.
- `cnt_dec_o` — out, 1 — decrement counter for `cnt_id_o`.
- `cnt_req_o` — out, 1 — counter access request.
- `cnt_gnt_i` — in, 1 — counter access granted, combinational in the same cycle.

## Operation

- `cnt_req_o = b_valid_i`, `cnt_id_o = b_i.id`. All other counter outputs are 0 unless `cnt_gnt_i` is high.
- No grant: `b_ready_o = 0` and no side effects.
- Granted, non-last beat (`cnt_len_i != 0`):
  - `b_ready_o = 1`, `cnt_dec_o = 1`, `cnt_set_err_o = b_i.resp[1]`.
  - Nothing is sent upstream; this holds regardless of upstream state.
- Granted, last beat (`cnt_len_i == 0`):
  - The beat is accepted only when the output path can take it (see Configuration).
  - On accept: `b_ready_o = 1`, `cnt_dec_o = 1`, `cnt_set_err_o = 0`, and the merged response is emitted.
  - Not accepted: `b_ready_o = 0`, `cnt_dec_o = 0`. Retry each cycle with request held.
- Merged response:
  - `id = b_i.id`, `user = b_i.user`.
  - `resp = b_i.resp` if `b_i.resp[1]`.
  - Else `resp = 2'b10` (SLVERR) if `cnt_err_i`.
  - Else `resp = b_i.resp`; OKAY and EXOKAY pass through.
- Single-beat bursts (`cnt_len_i == 0` on the first beat) pass straight through on the last-beat path.
- Interleaved IDs are legal. Each beat is resolved against its own ID's counter.

## Timing

- Reset values: `b_valid_o = 0`, `b_o = 0`, `b_ready_o = 0`, all `cnt_*_o = 0`, output register empty.
- Reset asserted mid-burst: the output register is cleared and any pending merged response is dropped. Counter state belongs to the counter block.
- `b_ready_o` may depend combinationally on `b_valid_i`, `cnt_gnt_i`, `cnt_len_i` and, without the register, on `b_ready_i`.
- Upstream handshake:
  - Once `b_valid_o` is high, `b_o` is stable until `b_ready_i`.
  - `b_valid_o` does not drop without a handshake.
- Throughput: one downstream beat per cycle when granted and the output path is free.

## Configuration

- Macro: `AXI_BURST_SPLITTER_B_OUT_REG_EN`.
- Defined — registered output:
  - One-entry output register; latency from last-beat accept to `b_valid_o` is 1 cycle.
  - Last beat accepted when the register is empty or `b_valid_o && b_ready_i` in the same cycle. Full throughput: drain and fill in the same cycle.
  - `b_o`/`b_valid_o` are driven from flops.
- Undefined — combinational output:
  - `b_valid_o = b_valid_i && cnt_gnt_i && cnt_len_i == 0`, `b_o` = merged response, 0-cycle latency.
  - Last beat accepted only when `b_ready_i` is high. `b_ready_i` therefore reaches `b_ready_o` combinationally.

## Test plan

- Single beat, ID 3, len 0, resp OKAY, gnt=1, ready=1: exactly one `b_o` with {id 3, OKAY}. One `cnt_dec_o` pulse; `cnt_set_err_o` never high.
- Burst ID 1, len 3:
  - Four beats, resp OKAY, SLVERR, OKAY, OKAY.
  - Beat 2 pulses `cnt_set_err_o`. Counter model returns `cnt_err_i = 1` on the last beat.
  - Exactly one upstream B {id 1, SLVERR}; four `cnt_dec_o` pulses.
- Last-beat resp DECERR with `cnt_err_i = 1`: upstream resp is DECERR, not SLVERR.
- `cnt_gnt_i` held 0 for 5 cycles with `b_valid_i = 1`:
  - `b_ready_o = 0` throughout, no decrement, no output.
  - Beat accepted on the first granted cycle.
- `b_ready_i = 0` for 4 cycles on a last beat:
  - With the register: the first last beat is registered, the next last beat stalls, `b_o` is stable, and no decrement until drain.
  - Without the register: the beat stalls until ready.
- Interleave IDs 0 (len 1) and 2 (len 0): beats 0, 2, 0 give outputs {id 2} then {id 0}, both OKAY.

Source files
------------

// File: rtl/axi_burst_splitter_b_merge.sv
// B-path merge stage of the AXI burst splitter: folds the per-beat responses of a
// split burst into one worst-case B per original burst. Optional macro:
// AXI_BURST_SPLITTER_B_OUT_REG_EN registers the upstream B output (one entry).
module axi_burst_splitter_b_merge #(
    parameter  int unsigned IdWidth   = 0,
    parameter  int unsigned UserWidth = 0,
    localparam int unsigned BW        = IdWidth + 2 + UserWidth,
    localparam int unsigned IdW       = (IdWidth > 0) ? IdWidth : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [BW-1:0]  b_i,
    input  logic           b_valid_i,
    output logic           b_ready_o,
    output logic [BW-1:0]  b_o,
    output logic           b_valid_o,
    input  logic           b_ready_i,
    output logic [IdW-1:0] cnt_id_o,
    input  logic [7:0]     cnt_len_i,
    output logic           cnt_set_err_o,
    input  logic           cnt_err_i,
    output logic           cnt_dec_o,
    output logic           cnt_req_o,
    input  logic           cnt_gnt_i
);

    // Error responses (SLVERR/DECERR) win; otherwise a sticky error upgrades to SLVERR.
    function automatic logic [1:0] merge_resp(input logic [1:0] beat_resp,
                                              input logic       sticky_err);
        if (beat_resp[1]) begin
            return beat_resp;
        end else if (sticky_err) begin
            return 2'b10;
        end else begin
            return beat_resp;
        end
    endfunction

    logic [IdW-1:0] in_id;
    logic [1:0]     in_resp;
    logic [BW-1:0]  merged_b;
    logic           granted;
    logic           is_last;
    logic           out_free;
    logic           accept;

    assign in_id   = IdW'(b_i >> (UserWidth + 2));
    assign in_resp = b_i[UserWidth +: 2];
    assign granted = b_valid_i && cnt_gnt_i;
    assign is_last = (cnt_len_i == 8'd0);

    always_comb begin
        merged_b                = b_i;
        merged_b[UserWidth +: 2] = merge_resp(in_resp, cnt_err_i);
    end

`ifdef AXI_BURST_SPLITTER_B_OUT_REG_EN
    logic          vld_p1_q, vld_p1_d;
    logic [BW-1:0] data_p1_q, data_p1_d;

    // The register can take a new beat when empty or draining this same cycle.
    assign out_free = !vld_p1_q || b_ready_i;

    always_comb begin
        vld_p1_d  = vld_p1_q;
        data_p1_d = data_p1_q;
        if (vld_p1_q && b_ready_i) begin
            vld_p1_d = 1'b0;
        end
        if (granted && is_last && out_free) begin
            vld_p1_d  = 1'b1;
            data_p1_d = merged_b;
        end
    end

    // Stage p1: merged response held until upstream handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1_q  <= 1'b0;
            data_p1_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            data_p1_q <= data_p1_d;
        end
    end

    assign b_valid_o = vld_p1_q;
    assign b_o       = data_p1_q;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk_i ^ rst_ni;
    assign out_free       = b_ready_i;
    assign b_valid_o      = granted && is_last;
    assign b_o            = merged_b;
`endif

    // Non-last beats never touch the upstream side, so they are never held back.
    assign accept        = granted && (!is_last || out_free);
    assign b_ready_o     = accept;
    assign cnt_dec_o     = accept;
    assign cnt_set_err_o = granted && !is_last && in_resp[1];
    assign cnt_req_o     = b_valid_i;
    assign cnt_id_o      = in_id;

endmodule
